// File: rtl/instr_mem_loader.sv
// ---------------------------------------------------------------------------
// instr_mem_loader
//  Writer side of the instruction-memory interface. Accepts a program frame
//  as a valid/ready byte stream, assembles big-endian 32-bit words and writes
//  them to instruction memory starting at word 0. The CPU pipeline is held
//  (cpu_hold = 1) until a frame has been loaded and its checksum matched.
//
//  Frame: LEN_HI, LEN_LO (N words, big-endian), 4*N data bytes (word MSB
//  first), CSUM (XOR of the data bytes only).
//
// Ports
//  clk          in   1         rising-edge clock
//  rst_n        in   1         asynchronous active-low reset
//  start        in   1         load request pulse (honoured in IDLE/DONE/ERROR)
//  in_valid     in   1         byte available on in_data
//  in_data      in   8         stream byte
//  in_ready     out  1         loader accepts a byte this cycle
//  mem_we       out  1         instruction memory write strobe (one cycle)
//  mem_addr     out  ADDR_W    word address
//  mem_wdata    out  32        word to write
//  cpu_hold     out  1         1 = pipeline must stall
//  done         out  1         load finished with good checksum (sticky)
//  error        out  1         length/checksum/timeout fault (sticky)
//  words_loaded out  ADDR_W+1  words written in the current/last load
// ---------------------------------------------------------------------------
module instr_mem_loader #(
   parameter int unsigned ADDR_W      = 10,
   parameter int unsigned TIMEOUT_CYC = 1000000
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              in_valid,
   input  logic [7:0]        in_data,
   output logic              in_ready,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic              cpu_hold,
   output logic              done,
   output logic              error,
   output logic [ADDR_W:0]   words_loaded
);

   localparam int unsigned CNT_W   = ADDR_W + 1;
   localparam int unsigned LEN_W   = 16;
   localparam int unsigned LEN_X_W = LEN_W + 1;
   localparam int unsigned TMO_W   = 32;

   // Largest legal word count: a completely full memory.
   localparam logic [LEN_X_W-1:0] MAX_LEN   = LEN_X_W'(1) << ADDR_W;
   localparam logic [TMO_W-1:0]   TMO_LIMIT = TMO_W'(TIMEOUT_CYC);
   localparam bit                 TMO_EN    = (TIMEOUT_CYC != 0);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LEN_HI,
      S_LEN_LO,
      S_DATA,
      S_WRITE,
      S_CSUM,
      S_DONE,
      S_ERROR
   } state_e;

   state_e               state_q, state_d;
   logic [LEN_W-1:0]     len_q, len_d;
   logic [23:0]          word_q, word_d;
   logic [1:0]           byte_cnt_q, byte_cnt_d;
   logic [7:0]           csum_q, csum_d;
   logic [TMO_W-1:0]     tmo_q, tmo_d;
   logic [CNT_W-1:0]     words_loaded_q, words_loaded_d;
   logic                 in_ready_q, in_ready_d;
   logic                 mem_we_q, mem_we_d;
   logic [ADDR_W-1:0]    mem_addr_q, mem_addr_d;
   logic [31:0]          mem_wdata_q, mem_wdata_d;
   logic                 cpu_hold_q, cpu_hold_d;
   logic                 done_q, done_d;
   logic                 error_q, error_d;

   logic                 xfer;
   logic [LEN_W-1:0]     len_new;
   logic                 last_word;
   logic                 waiting;

   assign xfer      = in_valid & in_ready_q;
   assign len_new   = {len_q[15:8], in_data};
   assign last_word = (LEN_X_W'(words_loaded_q) + LEN_X_W'(1)) == LEN_X_W'(len_q);

   // States in which the link is expected to deliver bytes (timeout armed).
   assign waiting = (state_q == S_LEN_HI) || (state_q == S_LEN_LO) ||
                    (state_q == S_DATA)   || (state_q == S_CSUM);

   // Next-state and registered-output computation.
   always_comb begin
      state_d        = state_q;
      len_d          = len_q;
      word_d         = word_q;
      byte_cnt_d     = byte_cnt_q;
      csum_d         = csum_q;
      tmo_d          = '0;
      words_loaded_d = words_loaded_q;
      mem_addr_d     = mem_addr_q;
      mem_wdata_d    = mem_wdata_q;

      case (state_q)
         S_IDLE, S_DONE, S_ERROR: begin
            if (start) begin
               state_d        = S_LEN_HI;
               words_loaded_d = '0;
               csum_d         = '0;
               byte_cnt_d     = '0;
            end
         end
         S_LEN_HI: begin
            if (xfer) begin
               len_d   = {in_data, 8'h00};
               state_d = S_LEN_LO;
            end
         end
         S_LEN_LO: begin
            if (xfer) begin
               len_d = len_new;
               if (len_new == '0) begin
                  state_d = S_CSUM;
               end else if ({1'b0, len_new} > MAX_LEN) begin
                  state_d = S_ERROR;
               end else begin
                  state_d = S_DATA;
               end
            end
         end
         S_DATA: begin
            if (xfer) begin
               word_d     = {word_q[15:0], in_data};
               csum_d     = csum_q ^ in_data;
               byte_cnt_d = byte_cnt_q + 2'd1;
               // Fourth byte completes the word; present it to memory next cycle.
               if (byte_cnt_q == 2'd3) begin
                  state_d     = S_WRITE;
                  mem_addr_d  = words_loaded_q[ADDR_W-1:0];
                  mem_wdata_d = {word_q, in_data};
               end
            end
         end
         S_WRITE: begin
            words_loaded_d = words_loaded_q + CNT_W'(1);
            state_d        = last_word ? S_CSUM : S_DATA;
         end
         S_CSUM: begin
            if (xfer) begin
               state_d = (in_data == csum_q) ? S_DONE : S_ERROR;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Idle-link watchdog; counter is cleared by any transfer or state exit.
      if (TMO_EN && waiting && !xfer) begin
         if ((tmo_q + TMO_W'(1)) == TMO_LIMIT) begin
            state_d = S_ERROR;
         end else begin
            tmo_d = tmo_q + TMO_W'(1);
         end
      end

      // Status outputs follow the state being entered so they stay registered.
      in_ready_d = (state_d == S_LEN_HI) || (state_d == S_LEN_LO) ||
                   (state_d == S_DATA)   || (state_d == S_CSUM);
      mem_we_d   = (state_d == S_WRITE);
      cpu_hold_d = (state_d != S_DONE);
      done_d     = (state_d == S_DONE);
      error_d    = (state_d == S_ERROR);
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= S_IDLE;
         len_q          <= '0;
         word_q         <= '0;
         byte_cnt_q     <= '0;
         csum_q         <= '0;
         tmo_q          <= '0;
         words_loaded_q <= '0;
         in_ready_q     <= 1'b0;
         mem_we_q       <= 1'b0;
         mem_addr_q     <= '0;
         mem_wdata_q    <= '0;
         cpu_hold_q     <= 1'b1;
         done_q         <= 1'b0;
         error_q        <= 1'b0;
      end else begin
         state_q        <= state_d;
         len_q          <= len_d;
         word_q         <= word_d;
         byte_cnt_q     <= byte_cnt_d;
         csum_q         <= csum_d;
         tmo_q          <= tmo_d;
         words_loaded_q <= words_loaded_d;
         in_ready_q     <= in_ready_d;
         mem_we_q       <= mem_we_d;
         mem_addr_q     <= mem_addr_d;
         mem_wdata_q    <= mem_wdata_d;
         cpu_hold_q     <= cpu_hold_d;
         done_q         <= done_d;
         error_q        <= error_d;
      end
   end

   assign in_ready     = in_ready_q;
   assign mem_we       = mem_we_q;
   assign mem_addr     = mem_addr_q;
   assign mem_wdata    = mem_wdata_q;
   assign cpu_hold     = cpu_hold_q;
   assign done         = done_q;
   assign error        = error_q;
   assign words_loaded = words_loaded_q;

endmodule

// File: tb/tb_instr_mem_loader.sv
// ---------------------------------------------------------------------------
// tb_instr_mem_loader
//  Self-checking bench for instr_mem_loader. Expected memory writes are pushed
//  to a scoreboard as frames are driven and popped when mem_we is observed.
// ---------------------------------------------------------------------------
module tb_instr_mem_loader;

   localparam int unsigned ADDR_W = 10;
   localparam int unsigned TMO    = 16;
   localparam int unsigned NMAX   = 1 << ADDR_W;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              start;
   logic              in_valid;
   logic [7:0]        in_data;
   logic              in_ready;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic              cpu_hold;
   logic              done;
   logic              error;
   logic [ADDR_W:0]   words_loaded;

   instr_mem_loader #(
      .ADDR_W      (ADDR_W),
      .TIMEOUT_CYC (TMO)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .in_valid     (in_valid),
      .in_data      (in_data),
      .in_ready     (in_ready),
      .mem_we       (mem_we),
      .mem_addr     (mem_addr),
      .mem_wdata    (mem_wdata),
      .cpu_hold     (cpu_hold),
      .done         (done),
      .error        (error),
      .words_loaded (words_loaded)
   );

   always #5 clk = ~clk;

   int unsigned       n_vec = 0;
   int unsigned       n_err = 0;
   logic [ADDR_W+31:0] exp_q[$];
   logic [31:0]       frame_words[$];
   logic              prev_we = 1'b0;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Write monitor: every strobe must be single-cycle and match the scoreboard.
   always @(negedge clk) begin
      logic [ADDR_W+31:0] e;
      if (!rst_n) begin
         prev_we = 1'b0;
      end else begin
         if (mem_we) begin
            check_val("we_pulse", 64'(prev_we), 64'd0);
            check_val("sb_nonempty", 64'(exp_q.size() > 0), 64'd1);
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               check_val("we_addr", 64'(mem_addr), 64'(e[ADDR_W+31:32]));
               check_val("we_data", 64'(mem_wdata), 64'(e[31:0]));
            end
         end
         prev_we = mem_we;
      end
   end

   task automatic idle_gap(input bit gaps);
      if (gaps) begin
         repeat ($urandom_range(0, 3)) begin
            in_valid = 1'b0;
            in_data  = 8'($urandom);
            @(negedge clk);
         end
      end
   endtask

   // Offer one byte and hold it until the loader takes it (bounded wait).
   task automatic send_byte(input logic [7:0] b, input bit gaps);
      int w = 0;
      idle_gap(gaps);
      in_valid = 1'b1;
      in_data  = b;
      while (!in_ready && w < 20) begin
         @(negedge clk);
         w++;
      end
      if (!in_ready) check_val("rdy_wait", 64'(in_ready), 64'd1);
      @(negedge clk);
      in_valid = 1'b0;
      in_data  = 8'h00;
   endtask

   task automatic do_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   function automatic logic [7:0] calc_csum();
      logic [7:0] c = 8'h00;
      foreach (frame_words[i]) begin
         c = c ^ frame_words[i][31:24] ^ frame_words[i][23:16]
               ^ frame_words[i][15:8]  ^ frame_words[i][7:0];
      end
      return c;
   endfunction

   task automatic fill_words(input int n);
      frame_words.delete();
      repeat (n) frame_words.push_back($urandom);
   endtask

   // Drive a frame; stop after data_lim data bytes, csum only if send_cs.
   task automatic send_frame(input logic [15:0] len, input logic [7:0] csum,
                             input int data_lim, input bit send_cs, input bit gaps);
      int nb = 0;
      logic [31:0] w;
      do_start();
      send_byte(len[15:8], gaps);
      send_byte(len[7:0], gaps);
      foreach (frame_words[i]) begin
         w = frame_words[i];
         for (int k = 3; k >= 0; k--) begin
            if (nb < data_lim) begin
               if (k == 0) exp_q.push_back({ADDR_W'(i), w});
               send_byte(w[8*k +: 8], gaps);
               nb++;
            end
         end
      end
      if (send_cs) send_byte(csum, gaps);
   endtask

   task automatic wait_end(input string tag);
      int c = 0;
      while (!(done || error) && c < 200) begin
         @(negedge clk);
         c++;
      end
      check_val(tag, 64'(done | error), 64'd1);
   endtask

   task automatic check_status(input string tag, input bit exp_done, input bit exp_err,
                               input int exp_wl);
      check_val({tag, "_done"}, 64'(done), 64'(exp_done));
      check_val({tag, "_error"}, 64'(error), 64'(exp_err));
      check_val({tag, "_hold"}, 64'(cpu_hold), 64'(!exp_done));
      check_val({tag, "_wl"}, 64'(words_loaded), 64'(exp_wl));
      check_val({tag, "_sb_left"}, 64'(exp_q.size()), 64'd0);
   endtask

   task automatic check_reset(input string tag);
      check_val({tag, "_in_ready"}, 64'(in_ready), 64'd0);
      check_val({tag, "_mem_we"}, 64'(mem_we), 64'd0);
      check_val({tag, "_mem_addr"}, 64'(mem_addr), 64'd0);
      check_val({tag, "_mem_wdata"}, 64'(mem_wdata), 64'd0);
      check_val({tag, "_cpu_hold"}, 64'(cpu_hold), 64'd1);
      check_val({tag, "_done"}, 64'(done), 64'd0);
      check_val({tag, "_error"}, 64'(error), 64'd0);
      check_val({tag, "_wl"}, 64'(words_loaded), 64'd0);
   endtask

   initial begin
      rst_n    = 1'b0;
      start    = 1'b0;
      in_valid = 1'b0;
      in_data  = 8'h00;
      repeat (3) @(negedge clk);
      check_reset("rst");
      rst_n = 1'b1;
      @(negedge clk);
      check_reset("rst_rel");

      // Reference two-word program, good checksum.
      frame_words.delete();
      frame_words.push_back(32'h20080005);
      frame_words.push_back(32'h2009000A);
      send_frame(16'd2, calc_csum(), 8, 1'b1, 1'b0);
      wait_end("t1_end");
      check_status("t1", 1'b1, 1'b0, 2);
      check_val("t1_addr_hold", 64'(mem_addr), 64'd1);
      check_val("t1_data_hold", 64'(mem_wdata), 64'h2009000A);

      // Same program, wrong checksum: words still written.
      send_frame(16'd2, 8'h00, 8, 1'b1, 1'b0);
      wait_end("t2_end");
      check_status("t2", 1'b0, 1'b1, 2);

      // Oversized length: fault right after LEN_LO, no writes.
      frame_words.delete();
      send_frame(16'h0401, 8'h00, 0, 1'b0, 1'b0);
      wait_end("t3_end");
      check_status("t3", 1'b0, 1'b1, 0);
      check_val("t3_in_ready", 64'(in_ready), 64'd0);

      // Empty program.
      send_frame(16'd0, 8'h00, 0, 1'b1, 1'b0);
      wait_end("t4a_end");
      check_status("t4a", 1'b1, 1'b0, 0);
      send_frame(16'd0, 8'h01, 0, 1'b1, 1'b0);
      wait_end("t4b_end");
      check_status("t4b", 1'b0, 1'b1, 0);

      // Link stalls after third data byte: fault exactly TMO cycles later.
      fill_words(1);
      send_frame(16'd1, 8'h00, 3, 1'b0, 1'b0);
      repeat (TMO - 1) @(negedge clk);
      check_val("t5_tmo_early", 64'(error), 64'd0);
      @(negedge clk);
      check_val("t5_tmo_fire", 64'(error), 64'd1);
      check_status("t5", 1'b0, 1'b1, 0);

      // Random valid gaps on a good frame.
      fill_words(6);
      send_frame(16'd6, calc_csum(), 24, 1'b1, 1'b1);
      wait_end("t6_end");
      check_status("t6", 1'b1, 1'b0, 6);

      // Reset in the middle of the second word, then a full reload.
      fill_words(3);
      send_frame(16'd3, calc_csum(), 6, 1'b0, 1'b0);
      rst_n = 1'b0;
      @(negedge clk);
      check_reset("t7_rst");
      rst_n = 1'b1;
      @(negedge clk);
      check_val("t7_sb_left", 64'(exp_q.size()), 64'd0);
      send_frame(16'd3, calc_csum(), 12, 1'b1, 1'b1);
      wait_end("t7_end");
      check_status("t7", 1'b1, 1'b0, 3);

      // Completely full memory.
      fill_words(NMAX);
      send_frame(16'(NMAX), calc_csum(), 4 * NMAX, 1'b1, 1'b0);
      wait_end("t8_end");
      check_status("t8", 1'b1, 1'b0, NMAX);
      check_val("t8_last_addr", 64'(mem_addr), 64'(NMAX - 1));
      check_val("t8_last_data", 64'(mem_wdata), 64'(frame_words[NMAX-1]));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
